// File: rtl/uart_rx_core_if.sv
// Register-side bundle of the UART receive engine: enables and configuration in,
// received character and its status flags out.
interface uart_rx_core_if #(
  parameter int MAX_UART_DATA_W = 8,
  parameter int TOTAL_CONF_W    = 5
);
  logic                       rx_en_i;
  logic [TOTAL_CONF_W-1:0]    rx_conf_i;
  logic                       rx_fifo_en_i;
  logic [MAX_UART_DATA_W-1:0] rx_data_o;
  logic                       rx_done_o;
  logic                       rx_busy_o;
  logic                       rx_parity_err_o;
  logic                       rx_frame_err_o;
  logic                       rx_fifo_push_o;

  modport master (
    output rx_en_i, rx_conf_i, rx_fifo_en_i,
    input  rx_data_o, rx_done_o, rx_busy_o, rx_parity_err_o, rx_frame_err_o, rx_fifo_push_o
  );

  modport slave (
    input  rx_en_i, rx_conf_i, rx_fifo_en_i,
    output rx_data_o, rx_done_o, rx_busy_o, rx_parity_err_o, rx_frame_err_o, rx_fifo_push_o
  );
endinterface

// File: rtl/uart_rx_core.sv
// UART receive engine: 16x oversampled start/data/parity/stop recovery with
// even-parity and framing checks, per-frame done and Rx FIFO push strobes.
module uart_rx_core #(
  parameter int MAX_UART_DATA_W = 8,
  parameter int STOP_CONF_W     = 2,
  parameter int DATA_CONF_W     = 2,
  parameter int SAMPLE_COUNT_W  = 4,
  parameter int DATA_COUNTER_W  = 3,
  parameter int TOTAL_CONF_W    = STOP_CONF_W + DATA_CONF_W + 1
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  input  logic           baud_en_i,
  input  logic           uart_rx_i,
  uart_rx_core_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_RESET, ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_DONE
  } state_e;

  localparam logic [SAMPLE_COUNT_W-1:0] MID_SAMPLE  = SAMPLE_COUNT_W'(7);
  localparam logic [SAMPLE_COUNT_W-1:0] LAST_SAMPLE = '1;

  logic [1:0]                 sync_q;
  logic                       rx_s;
  state_e                     state_q;
  logic [SAMPLE_COUNT_W-1:0]  cnt_q;
  logic [DATA_COUNTER_W-1:0]  idx_q;
  logic [DATA_COUNTER_W-1:0]  idx_max_q;
  logic [STOP_CONF_W-1:0]     stop_idx_q;
  logic [STOP_CONF_W-1:0]     stop_max_q;
  logic                       par_en_q;
  logic                       par_bit_q;
  logic                       frame_pend_q;
  logic [MAX_UART_DATA_W-1:0] shift_q;
  logic [MAX_UART_DATA_W-1:0] data_q;
  logic                       done_q;
  logic                       busy_q;
  logic                       perr_q;
  logic                       ferr_q;
  logic                       push_q;

  logic [DATA_CONF_W-1:0]     cfg_data;
  logic [STOP_CONF_W-1:0]     cfg_stop;
  logic                       cfg_par;

  assign cfg_data = bus.rx_conf_i[TOTAL_CONF_W-1 -: DATA_CONF_W];
  assign cfg_stop = bus.rx_conf_i[STOP_CONF_W:1];
  assign cfg_par  = bus.rx_conf_i[0];
  assign rx_s     = sync_q[1];

  // The line idles high, so the synchronizer resets to 1 to avoid a phantom start bit.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    if (!rstn_i) sync_q <= 2'b11;
    else         sync_q <= {sync_q[0], uart_rx_i};
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= ST_RESET;
      cnt_q        <= '0;
      idx_q        <= '0;
      idx_max_q    <= '0;
      stop_idx_q   <= '0;
      stop_max_q   <= '0;
      par_en_q     <= 1'b0;
      par_bit_q    <= 1'b0;
      frame_pend_q <= 1'b0;
      shift_q      <= '0;
      data_q       <= '0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      push_q       <= 1'b0;
    end else begin
      // Strobes last one clk_i cycle, not one baud period.
      done_q <= 1'b0;
      push_q <= 1'b0;
      if (baud_en_i) begin
        cnt_q <= cnt_q + 1'b1;
        unique case (state_q)
          ST_RESET: if (bus.rx_en_i) state_q <= ST_IDLE;
          ST_IDLE: begin
            if (!bus.rx_en_i) begin
              state_q <= ST_RESET;
            end else if (!rx_s) begin
              state_q      <= ST_START;
              cnt_q        <= '0;
              idx_q        <= '0;
              stop_idx_q   <= '0;
              idx_max_q    <= DATA_COUNTER_W'(32'd4 + 32'(cfg_data));
              stop_max_q   <= cfg_stop;
              par_en_q     <= cfg_par;
              par_bit_q    <= 1'b0;
              frame_pend_q <= 1'b0;
              shift_q      <= '0;
              busy_q       <= 1'b1;
            end
          end
          ST_START: begin
            if (cnt_q == MID_SAMPLE && rx_s) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else if (cnt_q == LAST_SAMPLE) begin
              state_q <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (cnt_q == MID_SAMPLE) shift_q[idx_q] <= rx_s;
            if (cnt_q == LAST_SAMPLE) begin
              if (idx_q == idx_max_q) state_q <= par_en_q ? ST_PARITY : ST_STOP;
              else                    idx_q   <= idx_q + 1'b1;
            end
          end
          ST_PARITY: begin
            if (cnt_q == MID_SAMPLE)  par_bit_q <= rx_s;
            if (cnt_q == LAST_SAMPLE) state_q   <= ST_STOP;
          end
          ST_STOP: begin
            if (cnt_q == MID_SAMPLE) begin
              if (!rx_s) frame_pend_q <= 1'b1;
              // Leave right after the last mid-sample so back-to-back frames are not missed.
              if (stop_idx_q == stop_max_q) begin
                state_q <= ST_DONE;
                data_q  <= shift_q;
                perr_q  <= par_en_q & (par_bit_q ^ (^shift_q));
                ferr_q  <= frame_pend_q | ~rx_s;
                done_q  <= 1'b1;
                push_q  <= bus.rx_fifo_en_i;
                busy_q  <= 1'b0;
              end
            end else if (cnt_q == LAST_SAMPLE) begin
              stop_idx_q <= stop_idx_q + 1'b1;
            end
          end
          ST_DONE: state_q <= bus.rx_en_i ? ST_IDLE : ST_RESET;
          default: state_q <= ST_RESET;
        endcase
      end
    end
  end

  assign bus.rx_data_o       = data_q;
  assign bus.rx_done_o       = done_q;
  assign bus.rx_busy_o       = busy_q;
  assign bus.rx_parity_err_o = perr_q;
  assign bus.rx_frame_err_o  = ferr_q;
  assign bus.rx_fifo_push_o  = push_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: a bench-side transmitter model drives the
// line, expected frames go to a scoreboard queue and are popped on each rx_done_o.
module tb_uart_rx_core;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       push;
  } exp_t;

  logic clk_i = 1'b0;
  logic rstn_i;
  logic baud_en = 1'b0;
  logic uart_rx_i;
  logic [1:0] div = '0;
  int   tick_cnt = 0;

  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  int   done_cnt = 0;
  int   push_cnt = 0;
  int   stray    = 0;
  int   done_tick = 0;
  logic prev_done = 1'b0;
  logic busy_seen = 1'b0;
  exp_t sb[$];
  exp_t mon_e;

  uart_rx_core_if #(.MAX_UART_DATA_W(8), .TOTAL_CONF_W(5)) bus ();

  uart_rx_core dut (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .baud_en_i (baud_en),
    .uart_rx_i (uart_rx_i),
    .bus       (bus)
  );

  always #5 clk_i = ~clk_i;

  // One baud tick every 4 clk_i cycles.
  always @(posedge clk_i) begin
    div     <= div + 2'd1;
    baud_en <= (div == 2'd3);
    if (baud_en) tick_cnt <= tick_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    while (!baud_en) @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input int n);
    uart_rx_i = v;
    repeat (n) tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input bit has_par,
                            input logic par_bit, input int nstop, input logic stop_val);
    drive(1'b0, 16);
    for (int i = 0; i < nbits; i++) drive(d[i], 16);
    if (has_par) drive(par_bit, 16);
    for (int i = 0; i < nstop; i++) drive(stop_val, 16);
    uart_rx_i = 1'b1;
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic perr, input logic ferr);
    exp_t e;
    e.data = d;
    e.perr = perr;
    e.ferr = ferr;
    e.push = bus.rx_fifo_en_i;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 400) begin
      tick();
      n++;
    end
    check("done_count", done_cnt, target);
  endtask

  // Output monitor and scoreboard consumer, sampling away from the active edge.
  initial begin
    forever begin
      @(negedge clk_i);
      if (bus.rx_busy_o) busy_seen = 1'b1;
      if (bus.rx_fifo_push_o) push_cnt++;
      if (bus.rx_fifo_push_o && !bus.rx_done_o) stray++;
      if (bus.rx_done_o) begin
        done_cnt++;
        done_tick = tick_cnt;
        check("done_width", prev_done, 1'b0);
        if (sb.size() == 0) begin
          stray++;
        end else begin
          mon_e = sb.pop_front();
          check("rx_data", bus.rx_data_o, mon_e.data);
          check("parity_err", bus.rx_parity_err_o, mon_e.perr);
          check("frame_err", bus.rx_frame_err_o, mon_e.ferr);
          check("fifo_push", bus.rx_fifo_push_o, mon_e.push);
        end
      end
      prev_done = bus.rx_done_o;
    end
  end

  initial begin
    int start_tick;
    int base;
    int pushes;
    logic [7:0] d;

    rstn_i           = 1'b0;
    uart_rx_i        = 1'b1;
    bus.rx_en_i      = 1'b0;
    bus.rx_conf_i    = 5'b11_00_0;
    bus.rx_fifo_en_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;
    check("rst_data", bus.rx_data_o, 8'h00);
    check("rst_done", bus.rx_done_o, 1'b0);
    check("rst_busy", bus.rx_busy_o, 1'b0);
    check("rst_perr", bus.rx_parity_err_o, 1'b0);
    check("rst_ferr", bus.rx_frame_err_o, 1'b0);
    check("rst_push", bus.rx_fifo_push_o, 1'b0);
    rstn_i      = 1'b1;
    bus.rx_en_i = 1'b1;
    drive(1'b1, 10);

    // 8N1, 0xA5, latency from the start edge to done about 152 ticks.
    busy_seen = 1'b0;
    expect_frame(8'hA5, 1'b0, 1'b0);
    start_tick = tick_cnt;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1);
    wait_done(1);
    check("latency_8n1", (done_tick - start_tick >= 150) && (done_tick - start_tick <= 156), 1'b1);
    check("busy_during_8n1", busy_seen, 1'b1);
    check("busy_after_8n1", bus.rx_busy_o, 1'b0);
    drive(1'b1, 40);

    // 7E2, 0x3C with correct even parity, then with the parity bit flipped.
    bus.rx_conf_i = 5'b10_01_1;
    d = 8'h3C;
    expect_frame(d & 8'h7F, 1'b0, 1'b0);
    send_frame(d, 7, 1'b1, ^(d & 8'h7F), 2, 1'b1);
    wait_done(2);
    drive(1'b1, 40);
    expect_frame(d & 8'h7F, 1'b1, 1'b0);
    send_frame(d, 7, 1'b1, ~(^(d & 8'h7F)), 2, 1'b1);
    wait_done(3);
    drive(1'b1, 40);

    // Glitch shorter than half a bit: busy pulses, no frame, flags held.
    busy_seen = 1'b0;
    drive(1'b0, 4);
    drive(1'b1, 40);
    check("glitch_busy_pulse", busy_seen, 1'b1);
    check("glitch_busy_clear", bus.rx_busy_o, 1'b0);
    check("glitch_no_done", done_cnt, 3);
    check("glitch_data_held", bus.rx_data_o, 8'h3C);
    check("glitch_perr_held", bus.rx_parity_err_o, 1'b1);

    // 5N1 with the stop bit forced low: data still delivered, framing error set.
    bus.rx_conf_i = 5'b00_00_0;
    expect_frame(8'h15, 1'b0, 1'b1);
    send_frame(8'h15, 5, 1'b0, 1'b0, 1, 1'b0);
    wait_done(4);
    drive(1'b1, 60);
    check("ferr_no_extra_done", done_cnt, 4);

    // Back-to-back 8N1 frames in FIFO mode: three pushes, none lost.
    bus.rx_conf_i    = 5'b11_00_0;
    bus.rx_fifo_en_i = 1'b1;
    pushes = push_cnt;
    expect_frame(8'h00, 1'b0, 1'b0);
    expect_frame(8'hFF, 1'b0, 1'b0);
    expect_frame(8'h81, 1'b0, 1'b0);
    send_frame(8'h00, 8, 1'b0, 1'b0, 1, 1'b1);
    send_frame(8'hFF, 8, 1'b0, 1'b0, 1, 1'b1);
    send_frame(8'h81, 8, 1'b0, 1'b0, 1, 1'b1);
    wait_done(7);
    drive(1'b1, 40);
    check("fifo_push_count", push_cnt - pushes, 3);
    bus.rx_fifo_en_i = 1'b0;

    // Start a frame after a framing-error frame so the async reset has flags to clear.
    bus.rx_conf_i = 5'b00_00_0;
    expect_frame(8'h0A, 1'b0, 1'b1);
    send_frame(8'h0A, 5, 1'b0, 1'b0, 1, 1'b0);
    wait_done(8);
    drive(1'b1, 60);
    bus.rx_conf_i = 5'b11_00_0;
    d = 8'h5A;
    drive(1'b0, 16);
    for (int i = 0; i < 3; i++) drive(d[i], 16);
    drive(d[3], 5);
    check("busy_mid_frame", bus.rx_busy_o, 1'b1);
    rstn_i = 1'b0;
    #1;
    check("arst_data", bus.rx_data_o, 8'h00);
    check("arst_busy", bus.rx_busy_o, 1'b0);
    check("arst_ferr", bus.rx_frame_err_o, 1'b0);
    check("arst_perr", bus.rx_parity_err_o, 1'b0);
    check("arst_done", bus.rx_done_o, 1'b0);
    check("arst_push", bus.rx_fifo_push_o, 1'b0);
    uart_rx_i = 1'b1;
    repeat (8) @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    drive(1'b1, 10);
    base = done_cnt;
    expect_frame(8'h5A, 1'b0, 1'b0);
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1, 1'b1);
    wait_done(base + 1);
    drive(1'b1, 20);

    check("scoreboard_empty", sb.size(), 0);
    check("no_stray_events", stray, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
